// File: rtl/owm_pkg.sv
// Shared 1-wire bit-master definitions: FSM states, slot timing in prescaler
// ticks, and status register bit positions.
package owm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_RELEASE,
        ST_RECOVER
    } owm_state_t;

    localparam int CNT_W = 10;

    // Slot timing in ticks: line low time, sample point, slot end.
    localparam logic [CNT_W-1:0] RST_LOW = 10'd480;
    localparam logic [CNT_W-1:0] RST_SMP = 10'd550;
    localparam logic [CNT_W-1:0] RST_END = 10'd960;
    localparam logic [CNT_W-1:0] W0_LOW  = 10'd60;
    localparam logic [CNT_W-1:0] W0_SMP  = 10'd70;
    localparam logic [CNT_W-1:0] W0_END  = 10'd70;
    localparam logic [CNT_W-1:0] W1_LOW  = 10'd6;
    localparam logic [CNT_W-1:0] W1_SMP  = 10'd15;
    localparam logic [CNT_W-1:0] W1_END  = 10'd70;

    localparam int STS_DAT  = 0;
    localparam int STS_RST  = 1;
    localparam int STS_OVD  = 2;
    localparam int STS_IEN  = 3;
    localparam int STS_BUSY = 4;
    localparam int STS_IRQ  = 7;

    typedef struct packed {
        logic [CNT_W-1:0] low;
        logic [CNT_W-1:0] smp;
        logic [CNT_W-1:0] fin;
    } slot_t;

    // A write-0 slot samples the line at slot end, so its sample point equals its end.
    function automatic slot_t slot_timing(input logic rst, input logic wr0);
        slot_t s;
        if (rst) begin
            s = '{low: RST_LOW, smp: RST_SMP, fin: RST_END};
        end else if (wr0) begin
            s = '{low: W0_LOW, smp: W0_SMP, fin: W0_END};
        end else begin
            s = '{low: W1_LOW, smp: W1_SMP, fin: W1_END};
        end
        return s;
    endfunction

endpackage

// File: rtl/owm_clk_div.sv
// Timebase prescaler: one-clock tick every 1 us, or every 1/8 us in overdrive
// (rounded down, at least one clock). Restart realigns the tick to a slot start.
module owm_clk_div #(
    parameter int FRQ = 24000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic ovd,
    output logic tick
);

    localparam int DIV_STD = FRQ / 1000000;
    localparam int DIV_OVD = (FRQ / 8000000 < 1) ? 1 : FRQ / 8000000;
    localparam int W       = (DIV_STD > 2) ? $clog2(DIV_STD) : 1;

    localparam logic [W-1:0] LIM_STD = W'(DIV_STD - 1);
    localparam logic [W-1:0] LIM_OVD = W'(DIV_OVD - 1);

    logic [W-1:0] div_cnt_reg;
    logic [W-1:0] lim;

    assign lim  = ovd ? LIM_OVD : LIM_STD;
    assign tick = (div_cnt_reg >= lim);

    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg >= lim) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/owm_bit_master.sv
// 1-wire bit-level master: runs one reset, write-0, write-1 or read slot per
// accepted command and reports the sampled line level through an 8-bit status.
module owm_bit_master
    import owm_pkg::*;
#(
    parameter int FRQ   = 24000000,
    parameter int OVD_E = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       avs_write,
    input  logic [7:0] avs_writedata,
    input  logic       avs_read,
    output logic [7:0] avs_readdata,
    output logic       irq,
    output logic       owr_oe,
    input  logic       owr_i
);

    owm_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       sync_reg;
    logic             dat_reg;
    logic             rst_reg;
    logic             ovd_reg;
    logic             ien_reg;
    logic             busy_reg;
    logic             irq_reg;
    logic             wr0_reg;
    logic             tick;
    logic             accept;
    logic             slot_done;
    slot_t            slot;

    assign accept    = avs_write && !busy_reg;
    assign cnt_next  = cnt_reg + 1'b1;
    assign slot      = slot_timing(rst_reg, wr0_reg);
    assign slot_done = tick && (cnt_next == slot.fin) &&
                       (state_reg == ST_RELEASE || state_reg == ST_RECOVER);

    owm_clk_div #(
        .FRQ(FRQ)
    ) u_clk_div (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(accept),
        .ovd    (ovd_reg),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sync_reg  <= 2'b11;
            dat_reg   <= 1'b1;
            rst_reg   <= 1'b0;
            ovd_reg   <= 1'b0;
            ien_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            irq_reg   <= 1'b0;
            wr0_reg   <= 1'b0;
            owr_oe    <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], owr_i};
            if (avs_read) begin
                irq_reg <= 1'b0;
            end
            // Interrupt enable is writable at any time, even mid-slot.
            if (avs_write) begin
                ien_reg <= avs_writedata[STS_IEN];
            end
            if (accept) begin
                dat_reg   <= avs_writedata[STS_DAT];
                rst_reg   <= avs_writedata[STS_RST];
                ovd_reg   <= (OVD_E != 0) && avs_writedata[STS_OVD];
                wr0_reg   <= !avs_writedata[STS_RST] && !avs_writedata[STS_DAT];
                busy_reg  <= 1'b1;
                irq_reg   <= 1'b0;
                cnt_reg   <= '0;
                owr_oe    <= 1'b1;
                state_reg <= ST_LOW;
            end else if (tick && state_reg != ST_IDLE) begin
                cnt_reg <= cnt_next;
                case (state_reg)
                    ST_LOW: begin
                        if (cnt_next == slot.low) begin
                            owr_oe    <= 1'b0;
                            state_reg <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt_next == slot.smp) begin
                            dat_reg   <= sync_reg[1];
                            state_reg <= ST_RECOVER;
                        end
                    end
                    default: ;
                endcase
                // Slot end wins over a coincident read clear.
                if (slot_done) begin
                    busy_reg  <= 1'b0;
                    irq_reg   <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        avs_readdata           = '0;
        avs_readdata[STS_DAT]  = dat_reg;
        avs_readdata[STS_RST]  = rst_reg;
        avs_readdata[STS_OVD]  = ovd_reg;
        avs_readdata[STS_IEN]  = ien_reg;
        avs_readdata[STS_BUSY] = busy_reg;
        avs_readdata[STS_IRQ]  = irq_reg;
    end

    assign irq = irq_reg && ien_reg;

endmodule

// File: tb/tb_owm_bit_master.sv
// Bench for owm_bit_master at 2 MHz: a slot-level model (times in clocks since
// command acceptance) checked every cycle, plus directed literal expectations.
module tb_owm_bit_master;

    localparam int FRQ     = 2000000;
    localparam int DIV_STD = FRQ / 1000000;
    localparam int DIV_OVD = (FRQ / 8000000 > 0) ? FRQ / 8000000 : 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       avs_write = 1'b0;
    logic [7:0] avs_writedata = 8'h00;
    logic       avs_read = 1'b0;
    logic [7:0] avs_readdata;
    logic       irq;
    logic       owr_oe;
    logic       owr_i;
    logic       slave_low = 1'b0;

    // Open-drain bus: low if the master or the simulated slave pulls it.
    assign owr_i = !(owr_oe || slave_low);

    always #5 clk = ~clk;

    owm_bit_master #(.FRQ(FRQ), .OVD_E(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .irq          (irq),
        .owr_oe       (owr_oe),
        .owr_i        (owr_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  line_hist [0:4095];
    bit  m_busy = 0, m_dat = 1, m_rst = 0, m_ovd = 0, m_ien = 0, m_irq = 0;
    int  t = 0, m_low = 0, m_smp = 0, m_end = 0;
    bit  cmp_en = 0;
    int  sl_a = 0, sl_b = 0;

    initial begin
        forever begin
            bit fin, was_busy;
            int sc;
            @(posedge clk);
            cyc++;
            line_hist[cyc % 4096] = owr_i;
            if (!reset_n) begin
                m_busy = 0; m_dat = 1; m_rst = 0; m_ovd = 0; m_ien = 0; m_irq = 0; t = 0;
            end else begin
                fin = 0;
                was_busy = m_busy;
                if (m_busy) begin
                    t++;
                    // Synchroniser: the level used is the one present two edges earlier.
                    if (t == m_smp) m_dat = line_hist[(cyc - 2) % 4096];
                    if (t == m_end) begin m_busy = 0; fin = 1; end
                end
                if (avs_read) m_irq = 0;
                if (avs_write) begin
                    m_ien = avs_writedata[3];
                    if (!was_busy) begin
                        m_dat = avs_writedata[0];
                        m_rst = avs_writedata[1];
                        m_ovd = avs_writedata[2];
                        sc = m_ovd ? DIV_OVD : DIV_STD;
                        if (m_rst) begin
                            m_low = 480 * sc; m_smp = 550 * sc; m_end = 960 * sc;
                        end else if (!m_dat) begin
                            m_low = 60 * sc; m_smp = 70 * sc; m_end = 70 * sc;
                        end else begin
                            m_low = 6 * sc; m_smp = 15 * sc; m_end = 70 * sc;
                        end
                        t = 0; m_busy = 1; m_irq = 0; acc_cyc = cyc;
                    end
                end
                if (fin) m_irq = 1;
            end
        end
    end

    // Slave: pulls the bus low during a window of clocks after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            slave_low = m_busy && (t >= sl_a) && (t < sl_b);
        end
    end

    // Per-cycle comparison against the model, plus measurement counters.
    int oe_cnt = 0;
    int irq_at = -1;
    bit irq_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("oe", {31'b0, owr_oe}, {31'b0, m_busy && (t < m_low)});
                check("readdata", {24'b0, avs_readdata},
                      {24'b0, m_irq, 2'b00, m_busy, m_ien, m_ovd, m_rst, m_dat});
                check("irq", {31'b0, irq}, {31'b0, m_irq && m_ien});
            end
            if (owr_oe === 1'b1) oe_cnt++;
            if (avs_readdata[7] === 1'b1 && !irq_prev) irq_at = cyc - acc_cyc;
            irq_prev = (avs_readdata[7] === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cmd(input logic [7:0] d);
        @(negedge clk);
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd();
        @(negedge clk);
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (avs_readdata[4] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'b0, n < budget}, 32'd1);
    endtask

    task automatic start(input logic [7:0] d, input int a, input int b);
        sl_a = a; sl_b = b; oe_cnt = 0; irq_at = -1;
        cmd(d);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp_en = 1;
        check("reset_readdata", {24'b0, avs_readdata}, 32'h01);
        check("reset_oe", {31'b0, owr_oe}, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read slot, line idle high.
        start(8'h09, 0, 0);
        wait_idle(4000);
        check("w1_oe_clocks", oe_cnt, 12);
        check("w1_irq_at", irq_at, 140);
        @(negedge clk);
        avs_read = 1'b1;
        check("w1_read_data", {24'b0, avs_readdata}, 32'h89);
        @(negedge clk);
        avs_read = 1'b0;
        check("w1_irq_cleared", {31'b0, irq}, 32'd0);

        // Reset slot with a presence pulse 60..220 us after release.
        start(8'h02, 1080, 1400);
        repeat (1919) @(negedge clk);
        check("rst_busy_1919", {31'b0, avs_readdata[4]}, 32'd1);
        @(negedge clk);
        check("rst_busy_1920", {31'b0, avs_readdata[4]}, 32'd0);
        check("rst_oe_clocks", oe_cnt, 960);
        check("rst_presence", {24'b0, avs_readdata}, 32'h82);
        check("rst_irq_masked", {31'b0, irq}, 32'd0);

        // Write-0 slot; slave holds the bus low through slot end.
        start(8'h08, 118, 400);
        wait_idle(4000);
        check("w0_oe_clocks", oe_cnt, 120);
        check("w0_irq_at", irq_at, 140);
        check("w0_dat", {31'b0, avs_readdata[0]}, 32'd0);
        rd();

        // Write during a busy slot: only ien changes.
        start(8'h09, 0, 0);
        repeat (3) @(negedge clk);
        check("busy_mid", {31'b0, avs_readdata[4]}, 32'd1);
        cmd(8'h01);
        check("ien_updated", {31'b0, avs_readdata[3]}, 32'd0);
        wait_idle(4000);
        check("ign_oe_clocks", oe_cnt, 12);
        check("ign_irq_at", irq_at, 140);
        check("ign_irq_out", {31'b0, irq}, 32'd0);

        // Read coinciding with slot end keeps irq set.
        start(8'h09, 0, 0);
        repeat (139) @(negedge clk);
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        check("coinc_irq_sts", {31'b0, avs_readdata[7]}, 32'd1);
        check("coinc_irq", {31'b0, irq}, 32'd1);
        rd();
        check("coinc_cleared", {31'b0, avs_readdata[7]}, 32'd0);

        // Reset asserted mid reset-slot.
        start(8'h02, 0, 0);
        repeat (49) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_oe", {31'b0, owr_oe}, 32'd0);
        check("abort_readdata", {24'b0, avs_readdata}, 32'h01);
        repeat (200) @(negedge clk);
        check("abort_later", {24'b0, avs_readdata}, 32'h01);

        // Randomised commands, line windows, reads and writes while busy.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            int a, n;
            d = 8'($urandom);
            d[1] = ($urandom_range(0, 7) == 0);
            if (d[1]) begin
                a = $urandom_range(0, 1800);
                start(d, a, a + $urandom_range(0, 400));
            end else begin
                a = $urandom_range(0, 140);
                start(d, a, a + $urandom_range(0, 60));
            end
            n = 0;
            while (avs_readdata[4] === 1'b1 && n < 5000) begin
                @(negedge clk);
                avs_read = ($urandom_range(0, 15) == 0);
                avs_write = ($urandom_range(0, 63) == 0);
                avs_writedata = 8'($urandom);
                n++;
            end
            avs_read = 1'b0;
            avs_write = 1'b0;
            wait_idle(5000);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
